// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings, mailbox register map and FSM state type.
package ahblite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int unsigned CTRL_TX_FLUSH = 0;
  localparam int unsigned CTRL_RX_FLUSH = 1;
  localparam int unsigned CTRL_STALL_EN = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  // Assemble the STATUS register from FIFO flags and (already narrowed) counts.
  function automatic logic [31:0] pack_status(input logic       tx_full,
                                              input logic       tx_empty,
                                              input logic       rx_full,
                                              input logic       rx_empty,
                                              input logic [7:0] tx_count,
                                              input logic [7:0] rx_count);
    return {8'h00, rx_count, tx_count, 4'h0, rx_empty, rx_full, tx_empty, tx_full};
  endfunction

endpackage

// File: rtl/mailbox_fifo.sv
// Synchronous show-ahead FIFO with flush; flush wins over a same-edge push or pop.
module mailbox_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              do_push;
  logic              do_pop;

  // No bypass: a full FIFO refuses a push even when a pop happens on the same edge.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap modulo DEPTH; the count carries the extra bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/ahblite_mailbox.sv
// AHB-Lite mailbox: bus writes feed a TX stream FIFO, bus reads drain an RX stream FIFO.
module ahblite_mailbox
  import ahblite_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic              HWRITE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic [31:0]       HRDATA,
  output logic              HRESP,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned WW = $clog2(WAIT_MAX + 1);

  state_t            state_q;
  state_t            state_d;
  logic [1:0]        addr_q;
  logic              write_q;
  logic              size_err_q;
  logic              stall_en_q;
  logic [WW-1:0]     wait_q;

  logic              accept;
  logic              is_tx_wr;
  logic              is_rx_rd;
  logic              is_ctrl_wr;
  logic              illegal;
  logic              blocked;
  logic              fault;
  logic              stall;

  logic              bus_push;
  logic              bus_pop;
  logic              ctrl_wr;
  logic              wait_inc;
  logic              wait_clr;
  logic              tx_flush;
  logic              rx_flush;

  logic              tx_full;
  logic              tx_empty;
  logic [CW-1:0]     tx_count;
  logic              rx_full;
  logic              rx_empty;
  logic [CW-1:0]     rx_count;
  logic [DATA_W-1:0] rx_head;

  logic              unused_bits;

  // Only word offsets and the low data bits are meaningful to this slave.
  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HWDATA[31:DATA_W]};

  // Address-phase qualification and data-phase decode of the captured transfer.
  assign accept     = HSEL & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ)) & HREADY;
  assign is_tx_wr   = write_q & (addr_q == REG_TXDATA);
  assign is_rx_rd   = ~write_q & (addr_q == REG_RXDATA);
  assign is_ctrl_wr = write_q & (addr_q == REG_CTRL);
  assign illegal    = size_err_q | (write_q & ((addr_q == REG_RXDATA) | (addr_q == REG_STATUS)));
  assign blocked    = (is_tx_wr & tx_full) | (is_rx_rd & rx_empty);
  assign fault      = illegal | (blocked & (~stall_en_q | (wait_q == WW'(WAIT_MAX))));
  assign stall      = blocked & ~fault;

  // FSM state register.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: new transfers are only taken while this slave is ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (fault) begin
          state_d = ST_ERR2;
        end else if (!stall) begin
          state_d = accept ? ST_DATA : ST_IDLE;
        end
      end
      ST_ERR2: begin
        state_d = accept ? ST_DATA : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: bus handshake plus the side-effect strobes of a completing transfer.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    bus_push  = 1'b0;
    bus_pop   = 1'b0;
    ctrl_wr   = 1'b0;
    wait_inc  = 1'b0;
    wait_clr  = 1'b0;
    case (state_q)
      ST_DATA: begin
        if (fault) begin
          HREADYOUT = 1'b0;
          HRESP     = 1'b1;
          wait_clr  = 1'b1;
        end else if (stall) begin
          HREADYOUT = 1'b0;
          wait_inc  = 1'b1;
        end else begin
          wait_clr = 1'b1;
          bus_push = is_tx_wr;
          bus_pop  = is_rx_rd;
          ctrl_wr  = is_ctrl_wr;
        end
      end
      ST_ERR2: begin
        HRESP = 1'b1;
      end
      default: ;
    endcase
  end

  // Capture the address-phase controls of an accepted transfer.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      addr_q     <= REG_TXDATA;
      write_q    <= 1'b0;
      size_err_q <= 1'b0;
    end else if (accept && HREADYOUT) begin
      addr_q     <= HADDR[3:2];
      write_q    <= HWRITE;
      size_err_q <= (HSIZE != HSIZE_WORD);
    end
  end

  // Wait-state counter bounding how long a blocked transfer may stall.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wait_q <= '0;
    end else if (wait_clr) begin
      wait_q <= '0;
    end else if (wait_inc) begin
      wait_q <= wait_q + WW'(1);
    end
  end

  // CTRL storage; the flush bits are strobes and are never stored.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      stall_en_q <= 1'b0;
    end else if (ctrl_wr) begin
      stall_en_q <= HWDATA[CTRL_STALL_EN];
    end
  end

  assign tx_flush = ctrl_wr & HWDATA[CTRL_TX_FLUSH];
  assign rx_flush = ctrl_wr & HWDATA[CTRL_RX_FLUSH];

  // Read mux, driven only while a transfer is in its data phase.
  always_comb begin
    HRDATA = '0;
    if (state_q == ST_DATA) begin
      case (addr_q)
        REG_RXDATA: HRDATA = 32'(rx_head);
        REG_STATUS: HRDATA = pack_status(tx_full, tx_empty, rx_full, rx_empty,
                                         8'(tx_count), 8'(rx_count));
        REG_CTRL:   HRDATA[CTRL_STALL_EN] = stall_en_q;
        default:    HRDATA = '0;
      endcase
    end
  end

  mailbox_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_tx_fifo (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .push      (bus_push),
    .push_data (HWDATA[DATA_W-1:0]),
    .pop       (tx_ready),
    .flush     (tx_flush),
    .head      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  mailbox_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rx_fifo (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (bus_pop),
    .flush     (rx_flush),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;

endmodule

// File: tb/tb_ahblite_mailbox.sv
// Scoreboard bench for the AHB-Lite mailbox.
module tb_ahblite_mailbox;
  import ahblite_pkg::*;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned WAIT_MAX = 255;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic              HSEL;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic              HWRITE;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic [31:0]       HRDATA;
  logic              HRESP;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]       exp_q[$];
  logic [DATA_W-1:0] tx_model[$];

  ahblite_mailbox #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .HRESP     (HRESP),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready)
  );

  // Single slave on the bus: the bus-wide ready is this slave's ready.
  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input int txc, input int rxc);
    logic [31:0] s;
    s        = '0;
    s[0]     = (txc == DEPTH);
    s[1]     = (txc == 0);
    s[2]     = (rxc == DEPTH);
    s[3]     = (rxc == 0);
    s[15:8]  = 8'(txc);
    s[23:16] = 8'(rxc);
    return s;
  endfunction

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
    HWRITE = 1'b0;
    HSIZE  = HSIZE_WORD;
    HADDR  = '0;
  endtask

  // One non-pipelined transfer; expectations are queued at issue and popped at completion.
  // release_at > 0 pulses tx_ready once that many wait states have been seen.
  task automatic xfer(input string tag, input logic [1:0] idx, input logic w,
                      input logic [31:0] wd, input logic [2:0] sz,
                      input logic [31:0] exp_rd, input logic exp_resp,
                      input int exp_waits, input int release_at);
    logic [31:0] rd;
    logic        resp;
    logic        err1;
    logic        done;
    int          waits;
    exp_q.push_back(exp_rd);
    exp_q.push_back(32'(exp_resp));
    exp_q.push_back(32'(exp_waits));
    HSEL   = 1'b1;
    HADDR  = {28'h4000_000, idx, 2'b00};
    HTRANS = HTRANS_NONSEQ;
    HWRITE = w;
    HSIZE  = sz;
    @(posedge HCLK); #1;
    bus_idle();
    HWDATA = wd;
    rd = '0; resp = 1'b0; err1 = 1'b0; done = 1'b0; waits = 0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge HCLK);
      if (tx_ready) tx_ready = 1'b0;
      if (HREADYOUT) begin
        rd   = HRDATA;
        resp = HRESP;
        done = 1'b1;
      end else if (HRESP) begin
        err1 = 1'b1;
      end else begin
        waits++;
        if (release_at > 0 && waits == release_at) begin
          check_eq({tag, " release head"}, 32'(tx_data), 32'(tx_model[0]));
          void'(tx_model.pop_front());
          tx_ready = 1'b1;
        end
      end
      @(posedge HCLK); #1;
    end
    check_eq({tag, " completed"}, 32'(done), 32'd1);
    if (!w) check_eq({tag, " rdata"}, rd, exp_q.pop_front());
    else    void'(exp_q.pop_front());
    check_eq({tag, " resp"}, 32'(resp), exp_q.pop_front());
    check_eq({tag, " err1 cycle"}, 32'(err1), 32'(exp_resp));
    check_eq({tag, " waits"}, 32'(waits), exp_q.pop_front());
    if (w && idx == REG_TXDATA && !exp_resp) tx_model.push_back(wd[DATA_W-1:0]);
  endtask

  task automatic rx_send(input logic [DATA_W-1:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    @(posedge HCLK); #1;
    rx_valid = 1'b0;
  endtask

  task automatic drain_tx(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge HCLK);
      check_eq("drain valid", 32'(tx_valid), 32'd1);
      check_eq("drain data", 32'(tx_data), 32'(tx_model.pop_front()));
      tx_ready = 1'b1;
      @(posedge HCLK); #1;
      tx_ready = 1'b0;
    end
    @(negedge HCLK);
    check_eq("drained valid", 32'(tx_valid), 32'd0);
    @(posedge HCLK); #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn  = 1'b0;
    HWDATA   = '0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    bus_idle();
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check_eq("rst HREADYOUT", 32'(HREADYOUT), 32'd1);
    check_eq("rst HRESP", 32'(HRESP), 32'd0);
    check_eq("rst HRDATA", HRDATA, 32'd0);
    check_eq("rst tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst rx_ready", 32'(rx_ready), 32'd1);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // BUSY transfer must be ignored.
    HSEL = 1'b1; HTRANS = HTRANS_BUSY; HWRITE = 1'b1; HADDR = 32'h0;
    @(posedge HCLK); #1;
    bus_idle(); HWDATA = 32'h99;
    @(negedge HCLK);
    check_eq("busy ready", 32'(HREADYOUT), 32'd1);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    check_eq("busy no push", 32'(tx_valid), 32'd0);
    @(posedge HCLK); #1;

    // TX write then stream pop.
    xfer("tx 5a", REG_TXDATA, 1'b1, 32'hFFFF_FF5A, HSIZE_WORD, 32'h0, 1'b0, 0, 0);
    drain_tx(1);

    // RX fill and back-to-back reads.
    rx_send(8'h11);
    rx_send(8'h22);
    xfer("status rx2", REG_STATUS, 1'b0, 32'h0, HSIZE_WORD, exp_status(0, 2), 1'b0, 0, 0);
    exp_q.push_back(32'h11);
    exp_q.push_back(32'h22);
    HSEL = 1'b1; HADDR = 32'h4; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HSIZE = HSIZE_WORD;
    @(posedge HCLK); #1;
    HTRANS = HTRANS_SEQ;
    @(negedge HCLK);
    check_eq("b2b ready0", 32'(HREADYOUT), 32'd1);
    check_eq("b2b rd0", HRDATA, exp_q.pop_front());
    @(posedge HCLK); #1;
    bus_idle();
    @(negedge HCLK);
    check_eq("b2b ready1", 32'(HREADYOUT), 32'd1);
    check_eq("b2b rd1", HRDATA, exp_q.pop_front());
    @(posedge HCLK); #1;
    xfer("status rx0", REG_STATUS, 1'b0, 32'h0, HSIZE_WORD, exp_status(0, 0), 1'b0, 0, 0);

    // Empty RX read without stalling -> two-cycle ERROR.
    xfer("rx empty err", REG_RXDATA, 1'b0, 32'h0, HSIZE_WORD, 32'h0, 1'b1, 0, 0);
    xfer("status after err", REG_STATUS, 1'b0, 32'h0, HSIZE_WORD, exp_status(0, 0), 1'b0, 0, 0);

    // Stall on a full TX FIFO, released after ten wait states.
    xfer("ctrl stall", REG_CTRL, 1'b1, 32'h4, HSIZE_WORD, 32'h0, 1'b0, 0, 0);
    xfer("ctrl rd", REG_CTRL, 1'b0, 32'h0, HSIZE_WORD, 32'h4, 1'b0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      xfer("fill", REG_TXDATA, 1'b1, 32'(i * 3 + 1), HSIZE_WORD, 32'h0, 1'b0, 0, 0);
    end
    xfer("tx 17th", REG_TXDATA, 1'b1, 32'hC3, HSIZE_WORD, 32'h0, 1'b0, 10, 10);
    xfer("status full", REG_STATUS, 1'b0, 32'h0, HSIZE_WORD, exp_status(DEPTH, 0), 1'b0, 0, 0);
    drain_tx(DEPTH);

    // Empty RX read with stalling -> WAIT_MAX waits then ERROR.
    xfer("rx timeout", REG_RXDATA, 1'b0, 32'h0, HSIZE_WORD, 32'h0, 1'b1, WAIT_MAX, 0);

    // Illegal accesses.
    xfer("byte write", REG_TXDATA, 1'b1, 32'h77, 3'b000, 32'h0, 1'b1, 0, 0);
    @(negedge HCLK);
    check_eq("byte no push", 32'(tx_valid), 32'd0);
    @(posedge HCLK); #1;
    xfer("wr status", REG_STATUS, 1'b1, 32'h0, HSIZE_WORD, 32'h0, 1'b1, 0, 0);
    xfer("wr rxdata", REG_RXDATA, 1'b1, 32'h0, HSIZE_WORD, 32'h0, 1'b1, 0, 0);

    // TX flush with queued words.
    for (int i = 0; i < 3; i++) begin
      xfer("q3", REG_TXDATA, 1'b1, 32'(8'hA0 + i), HSIZE_WORD, 32'h0, 1'b0, 0, 0);
    end
    xfer("status q3", REG_STATUS, 1'b0, 32'h0, HSIZE_WORD, exp_status(3, 0), 1'b0, 0, 0);
    xfer("tx flush", REG_CTRL, 1'b1, 32'h1, HSIZE_WORD, 32'h0, 1'b0, 0, 0);
    tx_model.delete();
    @(negedge HCLK);
    check_eq("flush tx_valid", 32'(tx_valid), 32'd0);
    @(posedge HCLK); #1;
    xfer("status flushed", REG_STATUS, 1'b0, 32'h0, HSIZE_WORD, exp_status(0, 0), 1'b0, 0, 0);
    xfer("ctrl selfclear", REG_CTRL, 1'b0, 32'h0, HSIZE_WORD, 32'h0, 1'b0, 0, 0);

    // RX flush discards a producer push on the same edge.
    rx_send(8'h33);
    rx_valid = 1'b1; rx_data = 8'h44;
    xfer("rx flush", REG_CTRL, 1'b1, 32'h2, HSIZE_WORD, 32'h0, 1'b0, 0, 0);
    rx_valid = 1'b0;
    xfer("status rxflush", REG_STATUS, 1'b0, 32'h0, HSIZE_WORD, exp_status(0, 0), 1'b0, 0, 0);

    // Reset during a stall.
    xfer("ctrl stall2", REG_CTRL, 1'b1, 32'h4, HSIZE_WORD, 32'h0, 1'b0, 0, 0);
    HSEL = 1'b1; HADDR = 32'h4; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HSIZE = HSIZE_WORD;
    @(posedge HCLK); #1;
    bus_idle();
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check_eq("mid stall", 32'(HREADYOUT), 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    @(negedge HCLK);
    check_eq("rst stall ready", 32'(HREADYOUT), 32'd1);
    check_eq("rst stall resp", 32'(HRESP), 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    xfer("ctrl after rst", REG_CTRL, 1'b0, 32'h0, HSIZE_WORD, 32'h0, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
